flanger_mod: RTL and testbench

FLANGER_MOD -- requirements
Module: flanger_mod

---
 rtl/flanger_mod.sv | 208 ++++++++++++++++++++
 tb/tb_flanger_mod.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flanger_mod.sv
// Flanger: LFO-swept delay line with feedback and wet mix; FLANGER_MOD_INTERP_EN adds linear tap interpolation.
// Latency: out_valid pulses 5 enabled cycles after acceptance; one sample in flight, IDLE->RD_A->RD_B->CALC->WR->OUT.
// Backpressure: busy high while a sample is in flight, in_valid then ignored; clk_enable low freezes everything.
module flanger_mod #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clk_enable,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic [ADDR_W-1:0]        sweep_min,
    input  logic [ADDR_W-1:0]        sweep_max,
    input  logic [7:0]               rate,
    input  logic signed [15:0]       mix,
    input  logic signed [15:0]       fb,
    output logic                     busy,
    output logic                     out_valid,
    output logic signed [DATA_W-1:0] out_data
);
    localparam int LW    = ADDR_W + 8;
    localparam int XW    = LW + 2;
    localparam int DEPTH = 1 << ADDR_W;
    localparam int TW    = DATA_W + 2;
    localparam int PW    = TW + 16;
    localparam int SW    = PW + 1;

    typedef enum logic [2:0] {IDLE, RD_A, RD_B, CALC, WR, OUT} state_t;
    state_t state, state_nxt;

    logic [DATA_W-1:0]        mem [DEPTH];
    logic [ADDR_W-1:0]        wp;
    logic [ADDR_W:0]          fill;
    logic [LW-1:0]            lfo_d;
    logic                     dir_down;

    logic signed [DATA_W-1:0] smp, tap_a, out_q, wr_q;
    logic signed [15:0]       mix_q, fb_q;
    logic [ADDR_W-1:0]        d_int_q;

    function automatic logic signed [DATA_W-1:0] sat(input logic signed [SW-1:0] v);
        if (v[SW-1:DATA_W-1] == '0 || v[SW-1:DATA_W-1] == '1)
            return v[DATA_W-1:0];
        return v[SW-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else if (clk_enable)
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (in_valid)
                    state_nxt = RD_A;
            end
            RD_A: state_nxt = RD_B;
            RD_B: state_nxt = CALC;
            CALC: state_nxt = WR;
            WR:   state_nxt = OUT;
            OUT: begin
                out_valid = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // LFO: bring D into the current sweep window, use it, then take one triangle step.
    logic signed [XW-1:0] lo, hi, cur, up_v, dn_v, rate_x;
    logic [LW-1:0]        step;
    logic                 dir_step, halt;

    always_comb begin
        lo     = $signed({2'b00, sweep_min, 8'h00});
        hi     = $signed({2'b00, sweep_max, 8'h00});
        rate_x = $signed({{(XW-8){1'b0}}, rate});
        halt   = (sweep_min >= sweep_max);
        cur    = $signed({2'b00, lfo_d});
        if (halt || cur < lo)
            cur = lo;
        else if (cur > hi)
            cur = hi;
        up_v     = cur + rate_x;
        dn_v     = cur - rate_x;
        step     = cur[LW-1:0];
        dir_step = dir_down;
        if (!halt) begin
            if (!dir_down) begin
                if (up_v > hi) begin
                    step     = hi[LW-1:0];
                    dir_step = 1'b1;
                end else begin
                    step = up_v[LW-1:0];
                end
            end else begin
                if (dn_v < lo) begin
                    step     = lo[LW-1:0];
                    dir_step = 1'b0;
                end else begin
                    step = dn_v[LW-1:0];
                end
            end
        end
    end

    logic [ADDR_W-1:0] d_eff, addr_a;
    logic              ok_a;

    always_comb begin
        d_eff  = (d_int_q == '0) ? ADDR_W'(1) : d_int_q;
        addr_a = wp - d_eff;
        ok_a   = ({1'b0, d_eff} <= fill);
    end

    logic signed [TW-1:0] delayed;
    logic signed [PW-1:0] wet_p, fb_p;
    logic signed [SW-1:0] out_s, wr_s;

`ifdef FLANGER_MOD_INTERP_EN
    localparam int DW1 = DATA_W + 1;
    localparam int FW  = DATA_W + 10;
    logic signed [DATA_W-1:0] tap_b;
    logic [7:0]               d_frac_q;
    logic [ADDR_W-1:0]        addr_b;
    logic                     ok_b;
    logic signed [DW1-1:0]    diff;
    logic signed [FW-1:0]     frac_p;

    // Tap B sits one sample further back; its distance can reach the full depth.
    assign addr_b = addr_a - 1'b1;
    assign ok_b   = (({1'b0, d_eff} + 1'b1) <= fill);

    always_comb begin
        diff    = DW1'(tap_b) - DW1'(tap_a);
        frac_p  = FW'(diff) * FW'($signed({1'b0, d_frac_q}));
        delayed = TW'(tap_a) + TW'(frac_p >>> 8);
    end
`else
    always_comb begin
        delayed = TW'(tap_a);
    end
`endif

    always_comb begin
        wet_p = (PW'(delayed) * PW'(mix_q)) >>> 15;
        fb_p  = (PW'(delayed) * PW'(fb_q)) >>> 15;
        out_s = SW'(smp) + SW'(wet_p);
        wr_s  = SW'(smp) + SW'(fb_p);
    end

    // Sample datapath and delay-line RAM; not reset, fill count masks stale contents.
    always_ff @(posedge clk) begin
        if (clk_enable) begin
            if (state == IDLE && in_valid) begin
                smp     <= in_data;
                mix_q   <= mix;
                fb_q    <= fb;
                d_int_q <= cur[LW-1:8];
`ifdef FLANGER_MOD_INTERP_EN
                d_frac_q <= cur[7:0];
`endif
            end
            if (state == RD_A)
                tap_a <= ok_a ? mem[addr_a] : '0;
`ifdef FLANGER_MOD_INTERP_EN
            if (state == RD_B)
                tap_b <= ok_b ? mem[addr_b] : '0;
`endif
            if (state == CALC) begin
                out_q <= sat(out_s);
                wr_q  <= sat(wr_s);
            end
            if (state == WR)
                mem[wp] <= wr_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wp       <= '0;
            fill     <= '0;
            lfo_d    <= '0;
            dir_down <= 1'b0;
            out_data <= '0;
        end else if (clk_enable) begin
            if (state == IDLE && in_valid) begin
                lfo_d    <= step;
                dir_down <= dir_step;
            end
            if (state == WR) begin
                wp       <= wp + 1'b1;
                out_data <= out_q;
                if (!fill[ADDR_W])
                    fill <= fill + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_flanger_mod.sv
module tb_flanger_mod;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 10;
    localparam int MAXV   = (1 << (DATA_W-1)) - 1;
    localparam int MINV   = -(1 << (DATA_W-1));

    logic clk = 1'b0;
    logic reset, clk_enable, in_valid, busy, out_valid;
    logic signed [DATA_W-1:0] in_data, out_data;
    logic [ADDR_W-1:0] sweep_min, sweep_max;
    logic [7:0] rate;
    logic signed [15:0] mix, fb;

    flanger_mod #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .clk_enable(clk_enable),
        .in_valid(in_valid), .in_data(in_data),
        .sweep_min(sweep_min), .sweep_max(sweep_max), .rate(rate),
        .mix(mix), .fb(fb),
        .busy(busy), .out_valid(out_valid), .out_data(out_data)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int stall_mode = 0;   // 0: always enabled, 1: random stalls, 2: held stalled

    task automatic check_val(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model: full history of written samples plus the LFO position in 1/256 units.
    int hist[$];
    int exp_q[$];
    int obs_q[$];
    int lfo_pos;
    bit lfo_up;

    task automatic model_reset();
        hist.delete();
        exp_q.delete();
        obs_q.delete();
        lfo_pos = 0;
        lfo_up  = 1'b1;
    endtask

    function automatic int sat_m(input longint v);
        if (v > MAXV) return MAXV;
        if (v < MINV) return MINV;
        return int'(v);
    endfunction

    task automatic model_accept(input int x, input int mn, input int mx,
                                input int rt, input int mg, input int fg);
        int use_pos, d, n, a, delayed;
`ifdef FLANGER_MOD_INTERP_EN
        int b;
`endif
        if (mn >= mx) begin
            lfo_pos = mn * 256;
            use_pos = lfo_pos;
        end else begin
            if (lfo_pos < mn * 256) lfo_pos = mn * 256;
            if (lfo_pos > mx * 256) lfo_pos = mx * 256;
            use_pos = lfo_pos;
            if (lfo_up) begin
                lfo_pos = lfo_pos + rt;
                if (lfo_pos > mx * 256) begin lfo_pos = mx * 256; lfo_up = 1'b0; end
            end else begin
                lfo_pos = lfo_pos - rt;
                if (lfo_pos < mn * 256) begin lfo_pos = mn * 256; lfo_up = 1'b1; end
            end
        end
        d = use_pos / 256;
        if (d < 1) d = 1;
        n = hist.size();
        a = (d <= n) ? hist[n-d] : 0;
`ifdef FLANGER_MOD_INTERP_EN
        b = (d + 1 <= n) ? hist[n-d-1] : 0;
        delayed = a + (((b - a) * (use_pos % 256)) >>> 8);
`else
        delayed = a;
`endif
        exp_q.push_back(sat_m(longint'(x) + ((longint'(delayed) * mg) >>> 15)));
        hist.push_back(sat_m(longint'(x) + ((longint'(delayed) * fg) >>> 15)));
    endtask

    // Monitor: decisions are taken on the falling edge, ahead of the rising edge that acts on them.
    always @(negedge clk) begin
        if (!reset && clk_enable) begin
            if (in_valid && !busy)
                model_accept(int'(in_data), int'(sweep_min), int'(sweep_max),
                             int'(rate), int'(mix), int'(fb));
            if (out_valid) begin
                obs_q.push_back(int'(out_data));
                if (exp_q.size() == 0)
                    check_val("spurious_out", 1, 0);
                else
                    check_val("out_data", int'(out_data), exp_q.pop_front());
            end
        end
    end

    initial begin
        clk_enable = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (stall_mode)
                1:       clk_enable = ($urandom_range(0, 3) != 0);
                2:       clk_enable = 1'b0;
                default: clk_enable = 1'b1;
            endcase
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        model_reset();
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic send(input int data);
        int n = 0;
        in_data  = DATA_W'(data);
        in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (clk_enable && !busy) break;
            n++;
            if (n > 200) begin
                check_val("accept_timeout", n, 0);
                break;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check_val("drain_left", exp_q.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic set_params(input int mn, input int mx, input int rt, input int mg, input int fg);
        sweep_min = ADDR_W'(mn);
        sweep_max = ADDR_W'(mx);
        rate      = 8'(rt);
        mix       = 16'(mg);
        fb        = 16'(fg);
    endtask

    task automatic rand_params();
        set_params($urandom_range(0, 12),
                   ($urandom_range(0, 9) == 0) ? $urandom_range(0, 1023) : $urandom_range(0, 20),
                   $urandom_range(0, 255), $urandom_range(0, 65535), $urandom_range(0, 65535));
    endtask

    int imp_exp[8] = '{1000, 0, 0, 0, 999, 0, 0, 0};
    int stall_ok;

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_data = '0;
        set_params(0, 0, 0, 0, 0);
        model_reset();
        #2;
        check_val("rst_busy", busy, 0);
        check_val("rst_out_valid", out_valid, 0);
        check_val("rst_out_data", out_data, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Impulse through a fixed 4-sample delay.
        do_reset();
        set_params(4, 4, 37, 16'h7FFF, 0);
        for (int i = 0; i < 8; i++) send(i == 0 ? 1000 : 0);
        drain();
        check_val("impulse_count", obs_q.size(), 8);
        for (int i = 0; i < 8 && i < obs_q.size(); i++)
            check_val($sformatf("impulse_%0d", i), obs_q[i], imp_exp[i]);

        // in_valid held high: one acceptance every 6 cycles.
        do_reset();
        set_params(3, 3, 0, $urandom_range(0, 65535), $urandom_range(0, 65535));
        in_valid = 1'b1;
        for (int k = 0; k < 36; k++) begin
            in_data = DATA_W'($urandom);
            @(negedge clk);
            check_val("hs_busy", busy, int'((k % 6) != 0));
            check_val("hs_out_valid", out_valid, int'((k % 6) == 5));
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        drain();

        // Saturation at positive full scale.
        do_reset();
        set_params(1, 1, 0, 16'h7FFF, 0);
        for (int i = 0; i < 6; i++) send(MAXV);
        drain();
        check_val("sat_count", obs_q.size(), 6);
        for (int i = 0; i < obs_q.size(); i++)
            check_val($sformatf("sat_%0d", i), obs_q[i], MAXV);

        // Swept delay with constant input: wet path settles at 255.
        do_reset();
        set_params(2, 5, 128, 16'h7FFF, 0);
        for (int i = 0; i < 14; i++) send(256);
        drain();
        check_val("sweep_count", obs_q.size(), 14);
        for (int i = 6; i < obs_q.size(); i++)
            check_val($sformatf("sweep_%0d", i), obs_q[i], 511);

        // Stall mid-sample for 10 cycles.
        do_reset();
        rand_params();
        send(int'($urandom_range(0, 65535)) - 32768);
        send(int'($urandom_range(0, 65535)) - 32768);
        stall_mode = 2;
        @(posedge clk); #2;
        stall_ok = 1;
        repeat (10) begin
            @(negedge clk);
            if (!busy || out_valid || clk_enable) stall_ok = 0;
        end
        check_val("stall_held", stall_ok, 1);
        stall_mode = 0;
        drain();

        // Random traffic with random stalls and per-sample parameter changes.
        stall_mode = 1;
        do_reset();
        for (int i = 0; i < 300; i++) begin
            rand_params();
            send(int'($urandom_range(0, 65535)) - 32768);
        end
        drain();
        stall_mode = 0;

        // Reset asserted in CALC aborts the sample without writing the delay line.
        do_reset();
        rand_params();
        send(2000);
        @(posedge clk);
        @(posedge clk); #2;
        check_val("calc_busy", busy, 1);
        reset = 1'b1;
        #1;
        check_val("midrst_busy", busy, 0);
        check_val("midrst_out_valid", out_valid, 0);
        check_val("midrst_out_data", out_data, 0);
        model_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        set_params(1, 1, 0, 16'h7FFF, 0);
        send(1234);
        send(-500);
        drain();
        check_val("postrst_count", obs_q.size(), 2);
        if (obs_q.size() == 2) begin
            check_val("postrst_0", obs_q[0], 1234);
            check_val("postrst_1", obs_q[1], 733);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "time limit");
    end

endmodule
